// File: rtl/rr_mux_sched_16_pkg.sv
// Shared types and the round-robin pick function for the 16-way serial scheduler.
package rr_mux_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from the highest offset down so the nearest set bit after ptr wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            r;
        logic [SEL_W-1:0] j;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = ptr + SEL_W'(i);
            if (req[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_sched_16_if.sv
// Requester/output bundle of the scheduler; master is the scheduler side.
interface rr_mux_sched_16_if;
    import rr_mux_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] d;
    logic [NUM_REQ-1:0] last;
    logic               out_valid;
    logic               out_ready;
    logic               out_data;
    logic               out_last;
    logic [SEL_W-1:0]   out_sel;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ack;

    modport master (
        input  req, d, last, out_ready,
        output out_valid, out_data, out_last, out_sel, gnt, ack
    );

    modport slave (
        output req, d, last, out_ready,
        input  out_valid, out_data, out_last, out_sel, gnt, ack
    );

endinterface

// File: rtl/rr_mux_sched_16_mux.sv
// Plain 16:1 single-bit mux.
module mux_16x1
    import rr_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] din,
    input  logic [SEL_W-1:0]   sel,
    output logic               dout
);

    assign dout = din[sel];

endmodule

// File: rtl/rr_mux_sched_16.sv
// Round-robin scheduler sharing one serial valid/ready line among 16 requesters,
// with bursts bounded by the requester's last flag or MAX_BURST beats.
module rr_mux_sched_16
    import rr_mux_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_mux_sched_16_if.master  bus
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             busy;
    logic             owner_req;
    logic             d_sel;
    logic             last_sel;
    logic             beat_last;
    logic             xfer;
    logic             end_burst;
    logic [SEL_W-1:0] pick_ptr;
    pick_t            pk;

    mux_16x1 mux_d (
        .din  (bus.d),
        .sel  (sel_q),
        .dout (d_sel)
    );

    mux_16x1 mux_last (
        .din  (bus.last),
        .sel  (sel_q),
        .dout (last_sel)
    );

    assign busy      = (state_q == BUSY);
    assign owner_req = bus.req[sel_q];
    assign beat_last = last_sel | (cnt_q == CNT_MAX);
    assign xfer      = bus.out_valid & bus.out_ready;
    assign end_burst = xfer & beat_last;

    // While busy the next arbitration already assumes the owner is finishing.
    assign pick_ptr  = busy ? (sel_q + SEL_W'(1)) : ptr_q;
    assign pk        = rr_pick(bus.req, pick_ptr);

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = 1'b0;
        bus.out_last  = 1'b0;
        bus.gnt       = '0;
        bus.ack       = '0;
        if (busy) begin
            bus.out_valid = owner_req;
            bus.out_data  = d_sel;
            bus.out_last  = beat_last;
            bus.gnt       = NUM_REQ'(1) << sel_q;
            bus.ack       = (NUM_REQ'(1) << sel_q) & {NUM_REQ{owner_req & bus.out_ready}};
        end
    end

    assign bus.out_sel = sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pk.found) begin
                    state_d = BUSY;
                    sel_d   = pk.idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // A withdrawn owner is retired exactly like a completed burst, minus the ack.
                if (end_burst || !owner_req) begin
                    ptr_d = pick_ptr;
                    cnt_d = '0;
                    if (pk.found) begin
                        sel_d = pk.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_sched_16.sv
// Bench for rr_mux_sched_16: directed vector table, corner sequences, random vs. model.
module tb_rr_mux_sched_16;
    import rr_mux_pkg::*;

    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rr_mux_sched_16_if bus ();

    rr_mux_sched_16 #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner index, beats taken, priority pointer, as plain ints.
    bit m_busy;
    int m_own, m_beats, m_ptr;

    function automatic int m_pick(input logic [15:0] r, input int p);
        for (int i = 0; i < 16; i++)
            if (r[(p + i) % 16]) return (p + i) % 16;
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_own = 0; m_beats = 0; m_ptr = 0;
    endtask

    task automatic m_step();
        bit on, xf, endb;
        if (!m_busy) begin
            if (bus.req != 0) begin
                m_busy  = 1;
                m_own   = m_pick(bus.req, m_ptr);
                m_beats = 0;
            end
        end else begin
            on   = bus.req[m_own];
            xf   = on && bus.out_ready;
            endb = xf && (bus.last[m_own] || m_beats == MB - 1);
            if (endb || !on) begin
                m_ptr   = (m_own + 1) % 16;
                m_beats = 0;
                if (bus.req != 0) m_own = m_pick(bus.req, m_ptr);
                else m_busy = 0;
            end else if (xf) begin
                m_beats++;
            end
        end
    endtask

    task automatic m_check();
        logic        ev, ed, el;
        logic [15:0] eg, ea;
        ev = m_busy && bus.req[m_own];
        ed = m_busy && bus.d[m_own];
        el = m_busy && (bus.last[m_own] || m_beats == MB - 1);
        eg = m_busy ? (16'(1) << m_own) : 16'h0;
        ea = (ev && bus.out_ready) ? eg : 16'h0;
        chk("rnd_valid", bus.out_valid, ev);
        chk("rnd_data",  bus.out_data,  ed);
        chk("rnd_last",  bus.out_last,  el);
        chk("rnd_gnt",   bus.gnt,       eg);
        chk("rnd_ack",   bus.ack,       ea);
        if (m_busy) chk("rnd_sel", bus.out_sel, m_own);
    endtask

    task automatic do_reset();
        bus.req = '1; bus.d = '1; bus.last = '1; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_gnt",   bus.gnt,       0);
        chk("rst_ack",   bus.ack,       0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_last",  bus.out_last,  0);
        @(posedge clk);
        #1;
        bus.req = '0; bus.d = '0; bus.last = '0;
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [15:0] req, d, last;
        logic        rdy, valid, data, olast;
        logic [3:0]  sel;
        logic [15:0] gnt, ack;
    } vec_t;

    function automatic vec_t mkv(input logic [15:0] r, input logic [15:0] dd, input logic [15:0] l,
                                 input logic rd, input logic v, input logic da, input logic ol,
                                 input logic [3:0] s, input logic [15:0] g, input logic [15:0] a);
        vec_t x;
        x.req = r; x.d = dd; x.last = l; x.rdy = rd; x.valid = v; x.data = da;
        x.olast = ol; x.sel = s; x.gnt = g; x.ack = a;
        return x;
    endfunction

    vec_t vq[$];

    initial begin
        //         req      d        last   rdy v  dat lst sel gnt      ack
        vq.push_back(mkv(16'h0010, 16'h0010, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vq.push_back(mkv(16'h0010, 16'h0010, 16'h0000, 1, 1, 1, 0, 4, 16'h0010, 16'h0010));
        vq.push_back(mkv(16'h0010, 16'h0000, 16'h0000, 1, 1, 0, 0, 4, 16'h0010, 16'h0010));
        vq.push_back(mkv(16'h0010, 16'h0010, 16'h0010, 1, 1, 1, 1, 4, 16'h0010, 16'h0010));
        vq.push_back(mkv(16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 4, 16'h0010, 16'h0000));
        vq.push_back(mkv(16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000));
        vq.push_back(mkv(16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000));
        for (int i = 0; i < 3; i++)
            vq.push_back(mkv(16'h0001, 16'h0001, 16'h0000, 1, 1, 1, 0, 0, 16'h0001, 16'h0001));
        vq.push_back(mkv(16'h0001, 16'h0001, 16'h0000, 1, 1, 1, 1, 0, 16'h0001, 16'h0001));
        vq.push_back(mkv(16'h0001, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 16'h0001, 16'h0001));
        vq.push_back(mkv(16'h0080, 16'h0080, 16'h0000, 1, 0, 0, 0, 0, 16'h0001, 16'h0000));
        for (int i = 0; i < 5; i++)
            vq.push_back(mkv(16'h0080, 16'h0080, 16'h0000, 0, 1, 1, 0, 7, 16'h0080, 16'h0000));
        vq.push_back(mkv(16'h0080, 16'h0080, 16'h0000, 1, 1, 1, 0, 7, 16'h0080, 16'h0080));
        vq.push_back(mkv(16'h0081, 16'h0080, 16'h0080, 1, 1, 1, 1, 7, 16'h0080, 16'h0080));
        vq.push_back(mkv(16'h0081, 16'h0001, 16'h0000, 1, 1, 1, 0, 0, 16'h0001, 16'h0001));

        bus.req = '0; bus.d = '0; bus.last = '0; bus.out_ready = 1'b0;
        #1;
        do_reset();

        foreach (vq[k]) begin
            bus.req = vq[k].req; bus.d = vq[k].d; bus.last = vq[k].last;
            bus.out_ready = vq[k].rdy;
            #2;
            chk($sformatf("tbl%0d_valid", k), bus.out_valid, vq[k].valid);
            chk($sformatf("tbl%0d_data", k),  bus.out_data,  vq[k].data);
            chk($sformatf("tbl%0d_last", k),  bus.out_last,  vq[k].olast);
            chk($sformatf("tbl%0d_gnt", k),   bus.gnt,       vq[k].gnt);
            chk($sformatf("tbl%0d_ack", k),   bus.ack,       vq[k].ack);
            if (vq[k].gnt != 0) chk($sformatf("tbl%0d_sel", k), bus.out_sel, vq[k].sel);
            tick();
        end

        // Fairness: everyone requesting single-beat bursts rotates 0..15,0 without bubbles.
        do_reset();
        bus.req = 16'hFFFF; bus.last = 16'hFFFF; bus.d = 16'h5555; bus.out_ready = 1'b1;
        #2;
        chk("rot_idle_valid", bus.out_valid, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            #2;
            chk("rot_sel",   bus.out_sel,   i % 16);
            chk("rot_ack",   bus.ack,       32'(1) << (i % 16));
            chk("rot_valid", bus.out_valid, 1);
            chk("rot_data",  bus.out_data,  ((i % 16) % 2) == 0);
            tick();
        end

        // Owner 15 withdraws; arbitration wraps through 0,1 to 2 with a fresh beat count.
        do_reset();
        bus.req = 16'h8000; bus.d = 16'h8000; bus.out_ready = 1'b1;
        #2;
        chk("wrap_idle_gnt", bus.gnt, 0);
        tick();
        #2;
        chk("wrap_own15_gnt",   bus.gnt,       16'h8000);
        chk("wrap_own15_valid", bus.out_valid, 1);
        tick();
        bus.req = 16'h0004; bus.d = 16'h0004;
        #2;
        chk("wd_valid", bus.out_valid, 0);
        chk("wd_ack",   bus.ack,       0);
        chk("wd_gnt",   bus.gnt,       16'h8000);
        tick();
        for (int b = 0; b < 4; b++) begin
            #2;
            chk("wrap_sel",  bus.out_sel,  2);
            chk("wrap_last", bus.out_last, b == 3);
            chk("wrap_ack",  bus.ack,      16'h0004);
            tick();
        end

        // Async reset between edges while busy.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_gnt",   bus.gnt,       0);
        chk("arst_ack",   bus.ack,       0);
        bus.req = 16'h8001; bus.d = 16'h0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        #2;
        chk("arst_first_sel", bus.out_sel, 0);
        chk("arst_first_gnt", bus.gnt,     16'h0001);
        tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) bus.req = '0;
            else bus.req = bus.req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            bus.d         = 16'($urandom);
            bus.last      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #2;
            m_check();
            @(posedge clk);
            m_step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
